bpred_gshare: RTL



---
 rtl/bpred_gshare_if.sv | 26 ++
 rtl/bpred_gshare.sv | 115 +++++++++++
 2 files changed

// File: rtl/bpred_gshare_if.sv
// rtl/bpred_gshare_if.sv - fetch lookup, branch update and statistics bundle for bpred_gshare
interface bpred_gshare_if;
  logic [31:0] fetch_pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;
  logic [31:0] br_total_o;
  logic [31:0] br_miss_o;

  // Core side: drives fetch PC and resolved branches, observes predictions.
  modport master (
    output fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, br_total_o, br_miss_o
  );

  // Predictor side.
  modport slave (
    input  fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i,
    output pred_hit_o, pred_taken_o, pred_target_o, br_total_o, br_miss_o
  );
endinterface

// File: rtl/bpred_gshare.sv
// rtl/bpred_gshare.sv - tagged BTB plus gshare/bimodal PHT branch predictor with mispredict stats
module bpred_gshare #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 2,
  parameter int GHR_W = 6,
  parameter int TAG_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bpred_gshare_if.slave bp
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic              btb_valid_q  [ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q    [ENTRIES];
  logic [31:0]       btb_target_q [ENTRIES];
  logic [CNT_W-1:0]  pht_q        [ENTRIES];
  logic [31:0]       br_total_q;
  logic [31:0]       br_miss_q;

  // History zero-extended to index width; all zeros in bimodal mode.
  logic [IDX_W-1:0]  ghr_ext;

  logic [IDX_W-1:0]  f_idx, f_pidx, u_idx, u_pidx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  logic              f_hit;
  logic [CNT_W-1:0]  f_cnt, u_cnt, u_cnt_next;

  // Only the index and tag fields of the PCs matter; the rest is deliberately dropped.
  logic unused_pc;
  assign unused_pc = ^{bp.fetch_pc_i, bp.upd_pc_i};

  assign f_idx  = bp.fetch_pc_i[IDX_W+1:2];
  assign f_tag  = bp.fetch_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign f_pidx = f_idx ^ ghr_ext;
  assign u_idx  = bp.upd_pc_i[IDX_W+1:2];
  assign u_tag  = bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_pidx = u_idx ^ ghr_ext;

  // Zero-latency lookup: all three prediction outputs come from this one read.
  assign f_hit            = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign f_cnt            = pht_q[f_pidx];
  assign bp.pred_hit_o    = f_hit;
  assign bp.pred_taken_o  = f_hit & f_cnt[CNT_W-1];
  assign bp.pred_target_o = f_hit ? btb_target_q[f_idx] : 32'h0;

  assign bp.br_total_o = br_total_q;
  assign bp.br_miss_o  = br_miss_q;

  assign u_cnt = pht_q[u_pidx];

  // Saturating counter step toward the resolved direction.
  always_comb begin
    u_cnt_next = u_cnt;
    if (bp.upd_taken_i) begin
      if (u_cnt != CNT_MAX) u_cnt_next = u_cnt + CNT_W'(1);
    end else begin
      if (u_cnt != '0) u_cnt_next = u_cnt - CNT_W'(1);
    end
  end

  // Global history: shift in each resolved direction; absent in bimodal mode.
  if (GHR_W > 0) begin : g_hist
    logic [GHR_W-1:0] ghr_q;

    // History register, updated only on valid resolutions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ghr_q <= '0;
      end else if (bp.upd_valid_i) begin
        ghr_q <= GHR_W'({ghr_q, bp.upd_taken_i});
      end
    end

    assign ghr_ext = IDX_W'(ghr_q);
  end else begin : g_bimodal
    assign ghr_ext = '0;
  end

  // Valid bits and direction counters; taken branches allocate or replace the BTB slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_q[i] <= 1'b0;
        pht_q[i]       <= CNT_INIT;
      end
    end else if (bp.upd_valid_i) begin
      pht_q[u_pidx] <= u_cnt_next;
      if (bp.upd_taken_i) btb_valid_q[u_idx] <= 1'b1;
    end
  end

  // BTB payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (bp.upd_valid_i && bp.upd_taken_i) begin
      btb_tag_q[u_idx]    <= u_tag;
      btb_target_q[u_idx] <= bp.upd_target_i;
    end
  end

  // Debug statistics, saturating rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_total_q <= '0;
      br_miss_q  <= '0;
    end else if (bp.upd_valid_i) begin
      if (br_total_q != 32'hFFFF_FFFF) br_total_q <= br_total_q + 32'd1;
      if (bp.upd_mispred_i && (br_miss_q != 32'hFFFF_FFFF)) br_miss_q <= br_miss_q + 32'd1;
    end
  end

endmodule
